// File: rtl/gb_pkg.sv
// Shared definitions for the ghostbus host bridge: FSM states, default bus
// widths and the legal range of the read-latency parameter.
package gb_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WSTB  = 3'd1,
    RSTB  = 3'd2,
    RWAIT = 3'd3,
    RESP  = 3'd4
  } gb_state_e;

  localparam int GB_AW_DEF   = 24;
  localparam int GB_DW_DEF   = 32;
  localparam int GB_RLAT_MIN = 1;
  localparam int GB_RLAT_MAX = 15;
  localparam int GB_CNT_W    = 4;

endpackage

// File: rtl/gb_host_bridge_if.sv
// Host command/response channel plus the ghostbus port, bundled together.
// The master modport is the bridge's view; slave is the host/target side.
interface gb_host_bridge_if
  import gb_pkg::*;
#(
  parameter int AW = GB_AW_DEF,
  parameter int DW = GB_DW_DEF
);

  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;

  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;

  logic          GBPORT_clk;
  logic [AW-1:0] GBPORT_addr;
  logic [DW-1:0] GBPORT_dout;
  logic [DW-1:0] GBPORT_din;
  logic          GBPORT_we;
  logic          GBPORT_wstb;
  logic          GBPORT_rstb;

  modport master (
    input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, rsp_ready, GBPORT_din,
    output cmd_ready, rsp_valid, rsp_rdata,
    output GBPORT_clk, GBPORT_addr, GBPORT_dout, GBPORT_we, GBPORT_wstb, GBPORT_rstb
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_addr, cmd_wdata, rsp_ready, GBPORT_din,
    input  cmd_ready, rsp_valid, rsp_rdata,
    input  GBPORT_clk, GBPORT_addr, GBPORT_dout, GBPORT_we, GBPORT_wstb, GBPORT_rstb
  );

endinterface

// File: rtl/gb_host_bridge.sv
// Single-outstanding host-to-ghostbus bridge: one write strobe or one read
// strobe per command, reads returned after a fixed RLAT-cycle target latency.
module gb_host_bridge
  import gb_pkg::*;
#(
  parameter int AW   = GB_AW_DEF,
  parameter int DW   = GB_DW_DEF,
  parameter int RLAT = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  gb_host_bridge_if.master bus
);

  if (RLAT < GB_RLAT_MIN || RLAT > GB_RLAT_MAX) begin : g_rlat_range
    $error("gb_host_bridge: RLAT must lie in 1..15");
  end

  localparam logic [GB_CNT_W-1:0] RLAT_CNT = GB_CNT_W'(RLAT);

  gb_state_e           state;
  gb_state_e           state_nxt;
  logic [GB_CNT_W-1:0] cnt;
  logic [GB_CNT_W-1:0] cnt_nxt;
  logic                accept;
  logic                capture;

  logic                ready;
  logic                valid;
  logic                wstb;
  logic                rstb;
  logic                we;
  logic [AW-1:0]       addr_hold;
  logic [DW-1:0]       dout_hold;
  logic [DW-1:0]       rdata_hold;

  assign accept  = (state == IDLE) && bus.cmd_valid && ready;
  // Target data is valid during the RLAT-th cycle after the read strobe.
  assign capture = (state == RWAIT) && (cnt == RLAT_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = bus.cmd_we ? WSTB : RSTB;
          cnt_nxt   = '0;
        end
      end
      WSTB:  state_nxt = IDLE;
      RSTB: begin
        state_nxt = RWAIT;
        cnt_nxt   = GB_CNT_W'(1);
      end
      RWAIT: begin
        if (cnt == RLAT_CNT) state_nxt = RESP;
        else                 cnt_nxt   = cnt + 1'b1;
      end
      RESP:  if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake and strobe outputs are registered copies of the next state,
  // so they are glitch-free and all read zero while reset is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready      <= 1'b0;
      valid      <= 1'b0;
      wstb       <= 1'b0;
      rstb       <= 1'b0;
      we         <= 1'b0;
      addr_hold  <= '0;
      dout_hold  <= '0;
      rdata_hold <= '0;
    end else begin
      ready <= (state_nxt == IDLE);
      valid <= (state_nxt == RESP);
      wstb  <= (state_nxt == WSTB);
      rstb  <= (state_nxt == RSTB);
      if (accept) begin
        addr_hold <= bus.cmd_addr;
        we        <= bus.cmd_we;
        if (bus.cmd_we) dout_hold <= bus.cmd_wdata;
      end
      if (capture) rdata_hold <= bus.GBPORT_din;
    end
  end

  assign bus.cmd_ready   = ready;
  assign bus.rsp_valid   = valid;
  assign bus.rsp_rdata   = rdata_hold;
  assign bus.GBPORT_clk  = clk;
  assign bus.GBPORT_addr = addr_hold;
  assign bus.GBPORT_dout = dout_hold;
  assign bus.GBPORT_we   = we;
  assign bus.GBPORT_wstb = wstb;
  assign bus.GBPORT_rstb = rstb;

endmodule

// File: tb/tb_gb_host_bridge.sv
// Bench for gb_host_bridge: three bridges (RLAT 2, 1, 15), each with a
// 16-word ghostbus target that drives data only in its latency window.
module tb_gb_host_bridge;
  import gb_pkg::*;

  localparam int AW = GB_AW_DEF;
  localparam int DW = GB_DW_DEF;
  localparam int NI = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic          cv   [NI];
  logic          cwe  [NI];
  logic [AW-1:0] caddr[NI];
  logic [DW-1:0] cwd  [NI];
  logic          rr   [NI];
  logic          cr   [NI];
  logic          rv   [NI];
  logic [DW-1:0] rd   [NI];
  logic          gw   [NI];
  logic          gr   [NI];
  logic          gwe  [NI];
  logic          gck  [NI];
  logic [AW-1:0] gad  [NI];
  logic [DW-1:0] gdo  [NI];
  int            mon_w[NI];
  int            mon_r[NI];
  int            mon_bad[NI];

  function automatic int lat_of(int g);
    return (g == 0) ? 2 : ((g == 1) ? 1 : 15);
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int L = (g == 0) ? 2 : ((g == 1) ? 1 : 15);

    gb_host_bridge_if #(.AW(AW), .DW(DW)) bus ();
    gb_host_bridge #(.AW(AW), .DW(DW), .RLAT(L)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus.master)
    );

    logic [DW-1:0] tmem [16];
    logic [3:0]    t_idx = '0;
    int            t_age = 0;
    int            nw = 0, nr = 0, bad = 0;
    logic          pw = 1'b0, pr = 1'b0;

    assign bus.cmd_valid  = cv[g];
    assign bus.cmd_we     = cwe[g];
    assign bus.cmd_addr   = caddr[g];
    assign bus.cmd_wdata  = cwd[g];
    assign bus.rsp_ready  = rr[g];
    // Outside the latency window the target drives inverted (wrong) data.
    assign bus.GBPORT_din = (t_age == L) ? tmem[t_idx] : ~tmem[t_idx];

    assign cr[g]  = bus.cmd_ready;
    assign rv[g]  = bus.rsp_valid;
    assign rd[g]  = bus.rsp_rdata;
    assign gw[g]  = bus.GBPORT_wstb;
    assign gr[g]  = bus.GBPORT_rstb;
    assign gwe[g] = bus.GBPORT_we;
    assign gck[g] = bus.GBPORT_clk;
    assign gad[g] = bus.GBPORT_addr;
    assign gdo[g] = bus.GBPORT_dout;
    assign mon_w[g]   = nw;
    assign mon_r[g]   = nr;
    assign mon_bad[g] = bad;

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        t_age <= 0;
      end else if (bus.GBPORT_rstb) begin
        t_age <= 1;
        t_idx <= bus.GBPORT_addr[3:0];
      end else if (t_age != 0 && t_age < 40) begin
        t_age <= t_age + 1;
      end
    end

    always @(posedge clk) begin
      if (bus.GBPORT_wstb) tmem[bus.GBPORT_addr[3:0]] <= bus.GBPORT_dout;
    end

    always @(negedge clk) begin
      if (bus.GBPORT_wstb) nw <= nw + 1;
      if (bus.GBPORT_rstb) nr <= nr + 1;
      if ((bus.GBPORT_wstb && bus.GBPORT_rstb) || (bus.GBPORT_wstb && pw) ||
          (bus.GBPORT_rstb && pr))
        bad <= bad + 1;
      pw <= bus.GBPORT_wstb;
      pr <= bus.GBPORT_rstb;
    end
  end

  int            n_chk = 0;
  int            n_pass = 0;
  int            exp_w[NI];
  int            exp_r[NI];
  logic [DW-1:0] ref_mem[NI][16];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Waits for cmd_ready, presents one command, returns #1 after the accepting edge.
  task automatic issue(input int g, input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, output bit ok);
    int n = 0;
    @(negedge clk);
    while (!cr[g] && n < 64) begin
      @(negedge clk);
      n++;
    end
    ok = cr[g];
    if (!ok) begin
      chk("cmd_ready_timeout", {63'd0, cr[g]}, 64'd1);
      return;
    end
    cv[g] = 1'b1; cwe[g] = we; caddr[g] = a; cwd[g] = d;
    @(posedge clk);
    #1;
    cv[g] = 1'b0;
    if (we) exp_w[g]++;
    else    exp_r[g]++;
  endtask

  task automatic check_zero(input int g, input string tag);
    chk({tag, "_cmd_ready"}, {63'd0, cr[g]}, 64'd0);
    chk({tag, "_rsp_valid"}, {63'd0, rv[g]}, 64'd0);
    chk({tag, "_wstb"},      {63'd0, gw[g]}, 64'd0);
    chk({tag, "_rstb"},      {63'd0, gr[g]}, 64'd0);
    chk({tag, "_we"},        {63'd0, gwe[g]}, 64'd0);
    chk({tag, "_addr"},      64'(gad[g]), 64'd0);
    chk({tag, "_dout"},      64'(gdo[g]), 64'd0);
    chk({tag, "_rdata"},     64'(rd[g]), 64'd0);
  endtask

  task automatic read_resp(input int g, input logic [AW-1:0] a,
                           input logic [DW-1:0] exp_d, input int exp_lat);
    int n = 0;
    int hold;
    logic [DW-1:0] held;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        chk("rd_rstb", {63'd0, gr[g]}, 64'd1);
        chk("rd_addr", 64'(gad[g]), 64'(a));
        chk("rd_we",   {63'd0, gwe[g]}, 64'd0);
      end
    end while (!rv[g] && n < 40);
    chk("rd_latency", 64'(n), 64'(exp_lat));
    chk("rd_data", 64'(rd[g]), 64'(exp_d));
    held = rd[g];
    hold = $urandom_range(0, 3);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk("rd_hold_valid", {63'd0, rv[g]}, 64'd1);
      chk("rd_hold_data", 64'(rd[g]), 64'(held));
    end
    rr[g] = 1'b1;
    @(posedge clk);
    #1;
    rr[g] = 1'b0;
    @(negedge clk);
    chk("rd_release", {63'd0, rv[g]}, 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit            ok;
    logic [31:0]   r;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [3:0]    idx;
    logic          we;

    for (int g = 0; g < NI; g++) begin
      cv[g] = 1'b0; cwe[g] = 1'b0; caddr[g] = '0; cwd[g] = '0; rr[g] = 1'b0;
      exp_w[g] = 0; exp_r[g] = 0;
    end

    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_zero(0, "reset");
    chk("reset_ready_rlat1", {63'd0, cr[1]}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_reset_ready", {63'd0, cr[0]}, 64'd1);
    chk("gbport_clk_copy", {63'd0, gck[0]}, {63'd0, clk});

    // Directed write of 0x0A to 0x000040
    issue(0, 1'b1, 24'h000040, 32'h0000000A, ok);
    ref_mem[0][0] = 32'h0000000A;
    @(negedge clk);
    chk("wr_addr", 64'(gad[0]), 64'h40);
    chk("wr_dout", 64'(gdo[0]), 64'h0A);
    chk("wr_we", {63'd0, gwe[0]}, 64'd1);
    chk("wr_wstb", {63'd0, gw[0]}, 64'd1);
    chk("wr_rstb", {63'd0, gr[0]}, 64'd0);
    chk("wr_busy", {63'd0, cr[0]}, 64'd0);
    chk("wr_no_rsp", {63'd0, rv[0]}, 64'd0);
    @(negedge clk);
    chk("wr_wstb_end", {63'd0, gw[0]}, 64'd0);
    chk("wr_ready_back", {63'd0, cr[0]}, 64'd1);
    chk("wr_no_rsp2", {63'd0, rv[0]}, 64'd0);
    chk("wr_addr_hold", 64'(gad[0]), 64'h40);

    issue(0, 1'b1, 24'h000044, 32'h00000042, ok);
    ref_mem[0][4] = 32'h00000042;

    // Directed read of 0x000044 with RLAT=2
    issue(0, 1'b0, 24'h000044, 32'h0, ok);
    @(negedge clk);
    chk("rd2_rstb", {63'd0, gr[0]}, 64'd1);
    chk("rd2_addr", 64'(gad[0]), 64'h44);
    chk("rd2_we", {63'd0, gwe[0]}, 64'd0);
    chk("rd2_dout_hold", 64'(gdo[0]), 64'h42);
    chk("rd2_v0", {63'd0, rv[0]}, 64'd0);
    @(negedge clk);
    chk("rd2_rstb_end", {63'd0, gr[0]}, 64'd0);
    chk("rd2_v1", {63'd0, rv[0]}, 64'd0);
    @(negedge clk);
    chk("rd2_v2", {63'd0, rv[0]}, 64'd0);
    @(negedge clk);
    chk("rd2_valid", {63'd0, rv[0]}, 64'd1);
    chk("rd2_data", 64'(rd[0]), 64'h42);

    // Response back-pressure with a competing command waiting
    cv[0] = 1'b1; cwe[0] = 1'b1; caddr[0] = 24'h000047; cwd[0] = 32'h5A5A5A5A;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_valid", {63'd0, rv[0]}, 64'd1);
      chk("bp_data", 64'(rd[0]), 64'h42);
      chk("bp_ready", {63'd0, cr[0]}, 64'd0);
      chk("bp_no_wstb", {63'd0, gw[0]}, 64'd0);
    end
    cv[0] = 1'b0;
    rr[0] = 1'b1;
    @(posedge clk);
    #1;
    rr[0] = 1'b0;
    @(negedge clk);
    chk("bp_released", {63'd0, rv[0]}, 64'd0);
    chk("bp_idle", {63'd0, cr[0]}, 64'd1);
    chk("bp_no_accept", 64'(gdo[0]), 64'h42);

    // rsp_ready held high from IDLE onward: it must not shorten the read
    rr[0] = 1'b1;
    issue(0, 1'b0, 24'h000040, 32'h0, ok);
    @(negedge clk);
    chk("rr_early_rstb", {63'd0, gr[0]}, 64'd1);
    @(negedge clk);
    chk("rr_early_v1", {63'd0, rv[0]}, 64'd0);
    @(negedge clk);
    chk("rr_early_v2", {63'd0, rv[0]}, 64'd0);
    @(negedge clk);
    chk("rr_early_valid", {63'd0, rv[0]}, 64'd1);
    chk("rr_early_data", 64'(rd[0]), 64'h0A);
    @(negedge clk);
    chk("rr_early_done", {63'd0, rv[0]}, 64'd0);
    rr[0] = 1'b0;

    // Asynchronous reset in the middle of a read wait
    issue(0, 1'b0, 24'h000044, 32'h0, ok);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_zero(0, "async_rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_rel_ready", {63'd0, cr[0]}, 64'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("rst_no_stale", {63'd0, rv[0]}, 64'd0);
    end

    // Randomized write/read mixes on the RLAT=1 and RLAT=15 bridges
    for (int g = 1; g < NI; g++) begin
      for (int i = 0; i < 16; i++) begin
        r = $urandom;
        a = AW'(r);
        a[3:0] = 4'(i);
        d = $urandom;
        issue(g, 1'b1, a, d, ok);
        ref_mem[g][i] = d;
        @(negedge clk);
        chk("init_addr", 64'(gad[g]), 64'(a));
        chk("init_wstb", {63'd0, gw[g]}, 64'd1);
      end
      for (int i = 0; i < 40; i++) begin
        r   = $urandom;
        a   = AW'(r);
        idx = 4'($urandom_range(0, 15));
        a[3:0] = idx;
        we  = 1'($urandom_range(0, 1));
        d   = $urandom;
        issue(g, we, a, d, ok);
        if (ok && we) begin
          ref_mem[g][idx] = d;
          @(negedge clk);
          chk("mix_wr_addr", 64'(gad[g]), 64'(a));
          chk("mix_wr_dout", 64'(gdo[g]), 64'(d));
          chk("mix_wr_wstb", {63'd0, gw[g]}, 64'd1);
        end else if (ok) begin
          read_resp(g, a, ref_mem[g][idx], lat_of(g) + 2);
        end
      end
    end

    repeat (2) @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      chk("wstb_pulses", 64'(mon_w[g]), 64'(exp_w[g]));
      chk("rstb_pulses", 64'(mon_r[g]), 64'(exp_r[g]));
      chk("strobe_exclusive", 64'(mon_bad[g]), 64'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
